// File: rtl/axis_pkt_limiter.sv
// AXI-Stream max-length limiter: truncates oversize packets, 2-entry skid output, stats counters.
// Define AXIS_PKT_LIMITER_BYTE_CNT_EN to add the byte_cnt output.
module axis_pkt_limiter #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int unsigned MAX_BEATS  = 24,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_aresetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   input  logic                  clr_stats,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  trunc_cnt,
   output logic                  busy
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  byte_cnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

   localparam logic [15:0] MAX_N = 16'(MAX_BEATS);

   state_t r_state, w_state_nxt;
   logic [15:0] r_n, w_n_nxt, w_idx;
   logic w_accept, w_fwd, w_fwd_last, w_trunc;

   logic                  r_s_ready;
   logic                  r_out_valid, r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [KEEP_WIDTH-1:0] r_out_keep;
   logic                  r_skid_valid, r_skid_last;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic [KEEP_WIDTH-1:0] r_skid_keep;
   logic                  w_out_free, w_skid_valid_nxt;

   logic [CNT_WIDTH-1:0] r_pkt_cnt, r_trunc_cnt;

   assign w_accept = s_axis_tvalid && r_s_ready;
   assign w_idx    = r_n + 16'd1;

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_state <= IDLE;
         r_n     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_n     <= w_n_nxt;
      end
   end

   // w_idx is the 1-based position of the beat being accepted now.
   always_comb begin
      w_state_nxt = r_state;
      w_n_nxt     = r_n;
      w_fwd       = 1'b0;
      w_fwd_last  = 1'b0;
      w_trunc     = 1'b0;
      if (w_accept) begin
         unique case (r_state)
            IDLE, PASS: begin
               w_fwd = 1'b1;
               if (s_axis_tlast) begin
                  w_fwd_last  = 1'b1;
                  w_state_nxt = IDLE;
                  w_n_nxt     = '0;
               end else if (w_idx >= MAX_N) begin
                  w_fwd_last  = 1'b1;
                  w_trunc     = 1'b1;
                  w_state_nxt = DROP;
                  w_n_nxt     = '0;
               end else begin
                  w_state_nxt = PASS;
                  w_n_nxt     = w_idx;
               end
            end
            DROP: begin
               if (s_axis_tlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_out_free       = !r_out_valid || m_axis_tready;
   assign w_skid_valid_nxt = w_out_free ? (r_skid_valid && w_fwd) : (r_skid_valid || w_fwd);

   // Ready is registered from next-state values so it never depends on m_axis_tready.
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_s_ready    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_keep   <= '0;
         r_out_last   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_keep  <= '0;
         r_skid_last  <= 1'b0;
      end else begin
         r_s_ready <= (w_state_nxt == DROP) || !w_skid_valid_nxt;
         if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_valid  <= 1'b1;
               r_out_data   <= r_skid_data;
               r_out_keep   <= r_skid_keep;
               r_out_last   <= r_skid_last;
               r_skid_valid <= w_fwd;
               if (w_fwd) begin
                  r_skid_data <= s_axis_tdata;
                  r_skid_keep <= s_axis_tkeep;
                  r_skid_last <= w_fwd_last;
               end
            end else begin
               r_out_valid <= w_fwd;
               if (w_fwd) begin
                  r_out_data <= s_axis_tdata;
                  r_out_keep <= s_axis_tkeep;
                  r_out_last <= w_fwd_last;
               end
            end
         end else if (w_fwd) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= s_axis_tdata;
            r_skid_keep  <= s_axis_tkeep;
            r_skid_last  <= w_fwd_last;
         end
      end
   end

   // Clear has priority over a coincident increment.
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_pkt_cnt   <= '0;
         r_trunc_cnt <= '0;
      end else if (clr_stats) begin
         r_pkt_cnt   <= '0;
         r_trunc_cnt <= '0;
      end else begin
         if (w_fwd_last && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
         if (w_trunc && (r_trunc_cnt != '1)) r_trunc_cnt <= r_trunc_cnt + CNT_WIDTH'(1);
      end
   end

`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
   localparam int unsigned PC_W  = $clog2(KEEP_WIDTH + 1);
   localparam int unsigned SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

   logic [PC_W-1:0]      w_popcnt;
   logic [SUM_W-1:0]     w_byte_sum;
   logic [CNT_WIDTH-1:0] r_byte_cnt;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) w_popcnt = w_popcnt + PC_W'(s_axis_tkeep[i]);
   end

   assign w_byte_sum = SUM_W'(r_byte_cnt) + SUM_W'(w_popcnt);

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_byte_cnt <= '0;
      end else if (clr_stats) begin
         r_byte_cnt <= '0;
      end else if (w_fwd) begin
         r_byte_cnt <= (|w_byte_sum[SUM_W-1:CNT_WIDTH]) ? '1 : w_byte_sum[CNT_WIDTH-1:0];
      end
   end

   assign byte_cnt = r_byte_cnt;
`endif

   assign s_axis_tready = r_s_ready;
   assign m_axis_tvalid = r_out_valid;
   assign m_axis_tdata  = r_out_data;
   assign m_axis_tkeep  = r_out_keep;
   assign m_axis_tlast  = r_out_last;
   assign pkt_cnt       = r_pkt_cnt;
   assign trunc_cnt     = r_trunc_cnt;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_axis_pkt_limiter.sv
// Bench for axis_pkt_limiter: packet-level reference model, random valid/ready, two DUT configs.
// Byte counter checks compile in when AXIS_PKT_LIMITER_BYTE_CNT_EN is defined.
module tb_axis_pkt_limiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        sel;
   logic        s_tvalid, s_tlast, m_tready, clr;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;

   logic        s_tready0, m_tvalid0, m_tlast0, busy0;
   logic [63:0] m_tdata0;
   logic [7:0]  m_tkeep0;
   logic [31:0] pkt0, trunc0;
   logic        s_tready1, m_tvalid1, m_tlast1, busy1;
   logic [63:0] m_tdata1;
   logic [7:0]  m_tkeep1;
   logic [3:0]  pkt1, trunc1;

   logic        s_tready, m_tvalid, m_tlast, busy;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic [31:0] pkt, trunc;

   assign s_tready = sel ? s_tready1 : s_tready0;
   assign m_tvalid = sel ? m_tvalid1 : m_tvalid0;
   assign m_tdata  = sel ? m_tdata1 : m_tdata0;
   assign m_tkeep  = sel ? m_tkeep1 : m_tkeep0;
   assign m_tlast  = sel ? m_tlast1 : m_tlast0;
   assign busy     = sel ? busy1 : busy0;
   assign pkt      = sel ? {28'd0, pkt1} : pkt0;
   assign trunc    = sel ? {28'd0, trunc1} : trunc0;

`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
   logic [31:0] byte0, bytes;
   logic [3:0]  byte1;
   assign bytes = sel ? {28'd0, byte1} : byte0;
`endif

   axis_pkt_limiter #(.DATA_WIDTH(64), .MAX_BEATS(24), .CNT_WIDTH(32)) u_dut0 (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tready(s_tready0),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid0), .m_axis_tready(sel | m_tready),
      .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tlast(m_tlast0),
      .clr_stats(clr & ~sel), .pkt_cnt(pkt0), .trunc_cnt(trunc0), .busy(busy0)
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
      , .byte_cnt(byte0)
`endif
   );

   axis_pkt_limiter #(.DATA_WIDTH(64), .MAX_BEATS(1), .CNT_WIDTH(4)) u_dut1 (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid & sel), .s_axis_tready(s_tready1),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid1), .m_axis_tready(~sel | m_tready),
      .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tlast(m_tlast1),
      .clr_stats(clr & sel), .pkt_cnt(pkt1), .trunc_cnt(trunc1), .busy(busy1)
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
      , .byte_cnt(byte1)
`endif
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;        // input tlast (output tlast for out_q entries)
      logic        fwd;         // expected to be forwarded
      logic        flast;       // expected output tlast
      logic        drop_after;  // limiter discards input after this beat
   } beat_t;

   beat_t  in_q[$], exp_q[$], out_q[$];
   bit     rdy_q[$];
   int     checks, failures;
   int     hold_err, ready_err, g_lat, g_max;
   bit     g_timeout, g_in_drop;
   longint exp_pkt, exp_trunc, exp_bytes, g_cmax;

   function automatic longint sat(input longint v);
      return (v > g_cmax) ? g_cmax : v;
   endfunction

   // Packet-level model: the first g_max beats survive, the g_max-th is forced last if needed.
   function automatic void add_pkt(input int len, input bit end_last);
      for (int i = 1; i <= len; i++) begin
         beat_t b;
         b.data       = {$urandom, $urandom};
         b.keep       = 8'($urandom_range(1, 255));
         b.last       = end_last && (i == len);
         b.fwd        = (i <= g_max);
         b.flast      = b.last || (i == g_max);
         b.drop_after = b.fwd ? ((i == g_max) && !b.last) : !b.last;
         in_q.push_back(b);
         if (b.fwd) begin
            exp_q.push_back(b);
            exp_bytes = sat(exp_bytes + longint'($countones(b.keep)));
            if (b.flast) begin
               exp_pkt = sat(exp_pkt + 1);
               if (!b.last) exp_trunc = sat(exp_trunc + 1);
            end
         end
      end
   endfunction

   function automatic int count_mismatch();
      int n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
      int m = out_q.size() - exp_q.size();
      if (m < 0) m = -m;
      for (int i = 0; i < n; i++)
         if (out_q[i].data !== exp_q[i].data || out_q[i].keep !== exp_q[i].keep ||
             out_q[i].last !== exp_q[i].flast) m++;
      return m;
   endfunction

   task automatic clear_model();
      exp_pkt = 0; exp_trunc = 0; exp_bytes = 0; g_in_drop = 0;
      in_q.delete(); exp_q.delete(); out_q.delete(); rdy_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_model();
   endtask

   // Drives in_q with random valid gaps, collects outputs, models ready from occupancy.
   task automatic run_stream(input int vpct, input int rpct, input int budget);
      beat_t cur, held, o;
      bit have = 0, stalled = 0;
      int occ = 0, idle = 0, cyc = 0, first_acc = -1, first_out = -1;
      hold_err = 0; ready_err = 0; g_timeout = 0;
      while (1) begin
         if (!have && in_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
            cur = in_q.pop_front(); have = 1;
         end
         s_tvalid = have;
         if (have) begin s_tdata = cur.data; s_tkeep = cur.keep; s_tlast = cur.last; end
         if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
         else m_tready = ($urandom_range(0, 99) < rpct);
         @(negedge clk);
         if (s_tready !== ((g_in_drop || occ < 2) ? 1'b1 : 1'b0)) ready_err++;
         if (stalled && (m_tvalid !== 1'b1 || m_tdata !== held.data || m_tkeep !== held.keep ||
                         m_tlast !== held.last)) hold_err++;
         stalled   = m_tvalid && !m_tready;
         held.data = m_tdata; held.keep = m_tkeep; held.last = m_tlast;
         if (m_tvalid && first_out < 0) first_out = cyc;
         if (m_tvalid && m_tready) begin
            o.data = m_tdata; o.keep = m_tkeep; o.last = m_tlast;
            out_q.push_back(o);
            occ--;
         end
         if (have && s_tready) begin
            if (first_acc < 0) first_acc = cyc;
            if (cur.fwd) occ++;
            g_in_drop = cur.drop_after;
            have = 0;
         end
         @(posedge clk); #1;
         cyc++;
         idle = (!have && in_q.size() == 0 && !m_tvalid) ? idle + 1 : 0;
         if (idle >= 4) break;
         if (cyc >= budget) begin g_timeout = 1; break; end
      end
      s_tvalid = 0; s_tlast = 0; m_tready = 1;
      g_lat = first_out - first_acc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
      checks++; if ({m_tdata, m_tkeep, m_tlast} !== 73'd0) begin failures++; $display("FAIL rst_m_payload got=%h exp=0", {m_tdata, m_tkeep, m_tlast}); end
      checks++; if ({pkt, trunc, busy} !== 65'd0) begin failures++; $display("FAIL rst_stats got=%h exp=0", {pkt, trunc, busy}); end
      rst_n = 1'b1;
      #1;
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_ready_before_edge got=%b exp=0", s_tready); end
      @(posedge clk); #1;
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_ready_after_edge got=%b exp=1", s_tready); end
      clear_model();
   endtask

   task automatic test_basic();
      int n;
      add_pkt(10, 1);
      run_stream(100, 100, 500);
      n = out_q.size();
      checks++; if (n !== 10) begin failures++; $display("FAIL basic_beats got=%0d exp=10", n); end
      checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL basic_data got=%0d bad beats exp=0", count_mismatch()); end
      checks++; if (g_lat !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", g_lat); end
      checks++; if (pkt !== 32'(exp_pkt) || trunc !== 32'(exp_trunc)) begin failures++; $display("FAIL basic_cnt got=%0d/%0d exp=%0d/%0d", pkt, trunc, exp_pkt, exp_trunc); end
      checks++; if (ready_err !== 0 || hold_err !== 0 || g_timeout) begin failures++; $display("FAIL basic_flow got ready_err=%0d hold_err=%0d timeout=%0d exp=0", ready_err, hold_err, g_timeout); end
      out_q.delete(); exp_q.delete();
   endtask

   task automatic test_truncate();
      int n;
      add_pkt(30, 1);
      run_stream(100, 100, 500);
      n = out_q.size();
      checks++; if (n !== 24) begin failures++; $display("FAIL trunc_beats got=%0d exp=24", n); end
      checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL trunc_data got=%0d bad beats exp=0", count_mismatch()); end
      checks++; if (pkt !== 32'(exp_pkt) || trunc !== 32'(exp_trunc)) begin failures++; $display("FAIL trunc_cnt got=%0d/%0d exp=%0d/%0d", pkt, trunc, exp_pkt, exp_trunc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL trunc_busy got=%b exp=0", busy); end
      checks++; if (ready_err !== 0 || g_timeout) begin failures++; $display("FAIL trunc_ready got ready_err=%0d timeout=%0d exp=0", ready_err, g_timeout); end
      out_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      add_pkt(5, 1);
      rdy_q = '{1, 0, 0, 1, 1, 0, 0, 1};
      run_stream(100, 100, 500);
      checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL bp_data got=%0d bad beats exp=0", count_mismatch()); end
      checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
      checks++; if (ready_err !== 0 || g_timeout) begin failures++; $display("FAIL bp_ready got ready_err=%0d timeout=%0d exp=0", ready_err, g_timeout); end
      out_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int n;
      add_pkt(12, 0);
      run_stream(100, 100, 500);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({s_tready, m_tvalid, busy} !== 3'b000 || pkt !== 32'd0) begin failures++; $display("FAIL mid_rst_outputs got=%b%b%b pkt=%0d exp=0", s_tready, m_tvalid, busy, pkt); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_model();
      add_pkt(18, 1);
      run_stream(100, 100, 500);
      n = out_q.size();
      checks++; if (n !== 18 || count_mismatch() !== 0) begin failures++; $display("FAIL mid_data got beats=%0d bad=%0d exp=18/0", n, count_mismatch()); end
      checks++; if (pkt !== 32'd1 || trunc !== 32'd0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d exp=1/0", pkt, trunc); end
      out_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         if (r == 3) begin
            clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
            exp_pkt = 0; exp_trunc = 0; exp_bytes = 0;
         end
         for (int p = 0; p < int'($urandom_range(3, 6)); p++) add_pkt(int'($urandom_range(1, 40)), 1);
         run_stream(int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), 4000);
         checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL rnd%0d_data got=%0d bad beats exp=0", r, count_mismatch()); end
         checks++; if (hold_err !== 0 || ready_err !== 0 || g_timeout) begin failures++; $display("FAIL rnd%0d_flow got hold=%0d ready=%0d timeout=%0d exp=0", r, hold_err, ready_err, g_timeout); end
         checks++; if (pkt !== 32'(exp_pkt) || trunc !== 32'(exp_trunc)) begin failures++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", r, pkt, trunc, exp_pkt, exp_trunc); end
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
         checks++; if (bytes !== 32'(exp_bytes)) begin failures++; $display("FAIL rnd%0d_bytes got=%0d exp=%0d", r, bytes, exp_bytes); end
`endif
         out_q.delete(); exp_q.delete();
      end
   endtask

`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
   task automatic test_byte_cnt();
      logic [7:0] keeps [3];
      beat_t b;
      keeps = '{8'hFF, 8'hFF, 8'h0F};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         b.data = {$urandom, $urandom}; b.keep = keeps[i]; b.last = (i == 2);
         b.fwd = 1; b.flast = (i == 2); b.drop_after = 0;
         in_q.push_back(b); exp_q.push_back(b);
      end
      run_stream(100, 100, 500);
      checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL bytes_data got=%0d bad beats exp=0", count_mismatch()); end
      checks++; if (bytes !== 32'd20) begin failures++; $display("FAIL bytes_sum got=%0d exp=20", bytes); end
      out_q.delete(); exp_q.delete();
   endtask
`endif

   task automatic test_max_one();
      sel = 1'b1; g_max = 1; g_cmax = 15;
      do_reset();
      for (int p = 0; p < 15; p++) add_pkt(int'($urandom_range(1, 3)), 1);
      run_stream(int'($urandom_range(50, 100)), int'($urandom_range(50, 100)), 2000);
      checks++; if (count_mismatch() !== 0) begin failures++; $display("FAIL max1_data got=%0d bad beats exp=0", count_mismatch()); end
      checks++; if (ready_err !== 0 || hold_err !== 0 || g_timeout) begin failures++; $display("FAIL max1_flow got ready=%0d hold=%0d timeout=%0d exp=0", ready_err, hold_err, g_timeout); end
      checks++; if (pkt !== 32'(exp_pkt) || trunc !== 32'(exp_trunc)) begin failures++; $display("FAIL max1_cnt got=%0d/%0d exp=%0d/%0d", pkt, trunc, exp_pkt, exp_trunc); end
      out_q.delete(); exp_q.delete();
      for (int p = 0; p < 3; p++) add_pkt(2, 1);
      run_stream(100, 100, 500);
      checks++; if (pkt !== 32'd15) begin failures++; $display("FAIL max1_sat got=%0d exp=15", pkt); end
      checks++; if (trunc !== 32'(exp_trunc)) begin failures++; $display("FAIL max1_trunc_sat got=%0d exp=%0d", trunc, exp_trunc); end
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
      checks++; if (bytes !== 32'(exp_bytes)) begin failures++; $display("FAIL max1_bytes got=%0d exp=%0d", bytes, exp_bytes); end
`endif
      out_q.delete(); exp_q.delete();
      // clr_stats in the same cycle as a tlast accept
      s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF;
      clr = 1'b1; m_tready = 1'b1;
      @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL clr_accept_ready got=%b exp=1", s_tready); end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (pkt !== 32'd0 || trunc !== 32'd0) begin failures++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", pkt, trunc); end
      checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin failures++; $display("FAIL clr_idle got busy=%b valid=%b exp=0", busy, m_tvalid); end
      sel = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0; sel = 1'b0;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1; clr = 1'b0;
      g_max = 24; g_cmax = 64'hFFFF_FFFF;
      test_reset();
      test_basic();
      test_truncate();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef AXIS_PKT_LIMITER_BYTE_CNT_EN
      test_byte_cnt();
`endif
      test_max_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
